// File: rtl/ch_sched.sv
// Channel scheduler: arbitrates bus bursts between filling the source FIFO
// (reads) and draining the destination FIFO (writes) for one transfer.
//
// state | meaning
// IDLE  | waiting for ctl_go
// CLR   | one-cycle FIFO clear
// ARB   | pick read or write burst (round-robin on tie)
// RD    | bus reads pushed into source FIFO
// WR    | destination FIFO popped onto the bus
// FIN   | one-cycle done pulse
module ch_sched #(
  parameter int BURST = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ctl_go,
  input  logic [23:0] dc0,
  input  logic        ss_start0,
  input  logic        ss_stop0,
  input  logic        ss_start1,
  input  logic        ss_end1,
  input  logic        beat_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic        ss_xfer0,
  output logic        ss_last0,
  output logic        ss_xfer1,
  output logic        m_reset0,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CLR, ARB, RD, WR, FIN} state_t;

  localparam logic [8:0] BURST_W = 9'(BURST);

  state_t      state, state_nxt;
  logic [23:0] rd_left, rd_left_nxt;
  logic [7:0]  bcnt, bcnt_nxt;
  logic        last_wr, last_wr_nxt;
  logic        rd_cand, wr_cand, bcnt_end;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      rd_left <= '0;
      bcnt    <= '0;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_left <= rd_left_nxt;
      bcnt    <= bcnt_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  assign rd_cand  = (rd_left != 24'd0) && ss_start0 && !ss_stop0;
  assign wr_cand  = ss_start1;
  assign bcnt_end = ({1'b0, bcnt} + 9'd1) == BURST_W;

  always_comb begin
    state_nxt   = state;
    rd_left_nxt = rd_left;
    bcnt_nxt    = bcnt;
    last_wr_nxt = last_wr;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    ss_xfer0    = 1'b0;
    ss_last0    = 1'b0;
    ss_xfer1    = 1'b0;
    m_reset0    = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (ctl_go) begin
          rd_left_nxt = dc0;
          state_nxt   = CLR;
        end
      end
      CLR: begin
        m_reset0  = 1'b1;
        state_nxt = ARB;
      end
      ARB: begin
        // on a tie the side not granted last wins
        if (wr_cand && (!rd_cand || !last_wr)) begin
          state_nxt   = WR;
          last_wr_nxt = 1'b1;
          bcnt_nxt    = '0;
        end else if (rd_cand) begin
          state_nxt   = RD;
          last_wr_nxt = 1'b0;
          bcnt_nxt    = '0;
        end
      end
      RD: begin
        bus_req  = 1'b1;
        ss_xfer0 = beat_ack;
        ss_last0 = beat_ack && (rd_left == 24'd1);
        if (beat_ack) begin
          rd_left_nxt = (rd_left != 24'd0) ? rd_left - 24'd1 : rd_left;
          bcnt_nxt    = bcnt + 8'd1;
          if (bcnt_end || rd_left == 24'd1) state_nxt = ARB;
        end else if (ss_stop0) begin
          state_nxt = ARB;
        end
      end
      WR: begin
        bus_req  = 1'b1;
        bus_we   = 1'b1;
        ss_xfer1 = beat_ack;
        if (beat_ack) begin
          bcnt_nxt = bcnt + 8'd1;
          if (ss_end1)       state_nxt = FIN;
          else if (bcnt_end) state_nxt = ARB;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ch_sched.sv
// Directed bench for ch_sched: expected grants and read-beat last flags are
// queued when stimulus is set up and checked as the DUT produces them.
module tb_ch_sched;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        ctl_go = 1'b0;
  logic [23:0] dc0 = '0;
  logic        ss_start0 = 1'b0, ss_stop0 = 1'b0, ss_start1 = 1'b0, ss_end1 = 1'b0;
  logic        beat_ack = 1'b0;
  logic        bus_req, bus_we, ss_xfer0, ss_last0, ss_xfer1, m_reset0, busy, done;

  ch_sched #(.BURST(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .ctl_go   (ctl_go),
    .dc0      (dc0),
    .ss_start0(ss_start0),
    .ss_stop0 (ss_stop0),
    .ss_start1(ss_start1),
    .ss_end1  (ss_end1),
    .beat_ack (beat_ack),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .ss_xfer0 (ss_xfer0),
    .ss_last0 (ss_last0),
    .ss_xfer1 (ss_xfer1),
    .m_reset0 (m_reset0),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we;
    int   beats;
  } grant_t;

  grant_t exp_g[$];
  logic   exp_last[$];
  int     total = 0, bad = 0;
  int     n_xfer0 = 0, n_xfer1 = 0, n_last0 = 0, n_done = 0, n_mrst = 0;
  logic   prev_req = 1'b0, g_we = 1'b0;
  int     g_beats = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic monitor();
    grant_t g;
    logic   e;
    n_xfer0 += int'(ss_xfer0);
    n_xfer1 += int'(ss_xfer1);
    n_last0 += int'(ss_last0);
    n_done  += int'(done);
    n_mrst  += int'(m_reset0);
    if (ss_xfer0) begin
      if (exp_last.size() == 0) chk("rd_beat_unexpected", 1, 0);
      else begin
        e = exp_last.pop_front();
        chk("ss_last0", ss_last0, e);
      end
    end
    if (bus_req) begin
      if (!prev_req) begin
        g_we    = bus_we;
        g_beats = 0;
      end
      g_beats += int'(ss_xfer0 | ss_xfer1);
    end else if (prev_req) begin
      if (exp_g.size() == 0) chk("grant_unexpected", 1, 0);
      else begin
        g = exp_g.pop_front();
        chk("grant_we", g_we, g.we);
        chk("grant_beats", g_beats, g.beats);
      end
    end
    prev_req = bus_req;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_g(input logic we, input int beats);
    grant_t g;
    g.we = we;
    g.beats = beats;
    exp_g.push_back(g);
  endtask

  task automatic push_last(input int beats, input logic last_at_end);
    for (int i = 1; i <= beats; i++) exp_last.push_back(last_at_end && (i == beats));
  endtask

  task automatic clr_cnt();
    n_xfer0 = 0; n_xfer1 = 0; n_last0 = 0; n_done = 0; n_mrst = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1; ctl_go = 1'b0;
    ss_start0 = 1'b0; ss_stop0 = 1'b0; ss_start1 = 1'b0; ss_end1 = 1'b0; beat_ack = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    clr_cnt();
  endtask

  task automatic go(input logic [23:0] len);
    dc0 = len; ctl_go = 1'b1;
    tick();
    ctl_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int start;
    start = n_done;
    for (int i = 0; i < limit && n_done == start; i++) tick();
    chk(tag, n_done - start, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // single write beat carrying the last flag: closes out an open transfer
  task automatic finish_with_write(input string tag);
    ss_start0 = 1'b0; ss_stop0 = 1'b0; ss_start1 = 1'b1; ss_end1 = 1'b1; beat_ack = 1'b1;
    push_g(1'b1, 1);
    wait_done(tag, 20);
    ss_start1 = 1'b0; ss_end1 = 1'b0;
  endtask

  initial begin
    // reset state
    wb_rst_i = 1'b1;
    tick(2);
    chk("reset_outputs", {bus_req, bus_we, ss_xfer0, ss_last0, ss_xfer1, m_reset0, busy, done}, 8'h00);
    wb_rst_i = 1'b0;
    clr_cnt();

    // 20 reads in bursts of 8/8/4, stray ctl_go mid-transfer ignored
    ss_start0 = 1'b1; beat_ack = 1'b1;
    push_g(1'b0, 8); push_g(1'b0, 8); push_g(1'b0, 4);
    push_last(20, 1'b1);
    go(24'd20);
    chk("s1_clr_pulse", m_reset0, 1);
    tick(3);
    ctl_go = 1'b1; tick(); ctl_go = 1'b0;
    tick(35);
    chk("s1_reads", n_xfer0, 20);
    chk("s1_last_cnt", n_last0, 1);
    chk("s1_grants_left", exp_g.size(), 0);
    chk("s1_mrst_once", n_mrst, 1);
    chk("s1_idle_arb_req", bus_req, 0);
    chk("s1_busy", busy, 1);
    finish_with_write("s1_done");

    // tie after reset goes to write first, next tie to read
    do_reset();
    ss_start0 = 1'b1; ss_start1 = 1'b1; beat_ack = 1'b1;
    push_g(1'b1, 8); push_g(1'b0, 8);
    push_last(8, 1'b0);
    go(24'd100);
    tick(19);
    ss_start0 = 1'b0; ss_start1 = 1'b0;
    tick(3);
    chk("s2_wr_beats", n_xfer1, 8);
    chk("s2_rd_beats", n_xfer0, 8);
    chk("s2_grants_left", exp_g.size(), 0);
    finish_with_write("s2_done");

    // almost-full with no ack after 3 reads ends the burst
    do_reset();
    ss_start0 = 1'b1; beat_ack = 1'b1;
    push_g(1'b0, 3);
    push_last(3, 1'b0);
    go(24'd50);
    tick(5);
    beat_ack = 1'b0; ss_stop0 = 1'b1;
    chk("s3_req_held", bus_req, 1);
    tick();
    chk("s3_req_fell", bus_req, 0);
    chk("s3_pushes", n_xfer0, 3);
    tick(2);
    chk("s3_no_regrant", n_xfer0, 3);
    chk("s3_busy", busy, 1);
    finish_with_write("s3_done");

    // write ends on beat 5 via ss_end1
    do_reset();
    ss_start1 = 1'b1; beat_ack = 1'b1;
    push_g(1'b1, 5);
    go(24'd0);
    tick(6);
    ss_end1 = 1'b1;
    tick();
    chk("s4_pops", n_xfer1, 5);
    chk("s4_done", done, 1);
    chk("s4_busy_fin", busy, 1);
    ss_start1 = 1'b0; ss_end1 = 1'b0;
    tick();
    chk("s4_busy_fell", busy, 0);
    chk("s4_done_fell", done, 0);
    tick(2);
    chk("s4_done_once", n_done, 1);

    // reset during read beat 4, then a fresh start clears the FIFOs again
    do_reset();
    ss_start0 = 1'b1; beat_ack = 1'b1;
    push_g(1'b0, 4);
    push_last(4, 1'b0);
    go(24'd50);
    tick(5);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    chk("s5_outputs_zero", {bus_req, bus_we, ss_xfer0, ss_last0, ss_xfer1, m_reset0, busy, done}, 8'h00);
    tick(3);
    chk("s5_no_done", n_done, 0);
    chk("s5_grants_left", exp_g.size(), 0);
    ss_start0 = 1'b0;
    go(24'd5);
    chk("s5_fresh_clr", m_reset0, 1);
    finish_with_write("s5_done");

    // zero-length transfer completes on the destination side alone
    do_reset();
    ss_start0 = 1'b1; ss_start1 = 1'b1; ss_end1 = 1'b1; beat_ack = 1'b1;
    push_g(1'b1, 1);
    go(24'd0);
    wait_done("s6_done", 20);
    chk("s6_no_reads", n_xfer0, 0);
    chk("s6_pops", n_xfer1, 1);

    tick(2);
    chk("end_grants_left", exp_g.size(), 0);
    chk("end_lasts_left", exp_last.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ch_sched.md
CH_SCHED -- requirements
Module: ch_sched

Interface
REQ-001 Parameter BURST, default 8, maximum beats per bus grant (range 1..255).
REQ-002 wb_clk_i  in  1  sole clock; all logic on the rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 ctl_go  in  1  one-cycle pulse that starts a transfer; sampled only in IDLE.
REQ-005 dc0  in  24  transfer length in 64-bit beats; sampled on the accepted ctl_go.
REQ-006 ss_start0 / ss_stop0  in  1 each  source FIFO has room for a burst / is almost full.
REQ-007 ss_start1  in  1  destination FIFO has a burst, or its tail is ready, to drain.
REQ-008 ss_end1  in  1  the destination FIFO head beat carries the last flag.
REQ-009 beat_ack  in  1  bus master completed one 64-bit beat this cycle.
REQ-010 bus_req  out  1  request bus beats.
REQ-011 bus_we  out  1  1 = write (drain destination FIFO); 0 = read (fill source FIFO).
REQ-012 ss_xfer0 / ss_last0  out  1 each  push a beat into the source FIFO / mark the final read beat.
REQ-013 ss_xfer1  out  1  pop a beat from the destination FIFO.
REQ-014 m_reset0  out  1  one-cycle FIFO clear pulse.
REQ-015 busy / done  out  1 each  transfer in progress / one-cycle completion pulse.

Function
REQ-016 The state machine SHALL have the states IDLE, CLR, ARB, RD, WR and FIN.
- IDLE: on ctl_go, load rd_left=dc0 and go to CLR.
- CLR: lasts one cycle with m_reset0=1, then go to ARB.
REQ-017 ARB SHALL evaluate two candidates.
- Read candidate: rd_left!=0 && ss_start0 && !ss_stop0.
- Write candidate: ss_start1.
- One candidate: go to its state next cycle.
- Both candidates: grant the one not granted last (round-robin); the first grant after reset goes to the write.
- Neither: stay in ARB.
REQ-018 On entry to RD or WR, beat counter bcnt SHALL clear to 0; bus_req=1 throughout RD/WR; bus_we=1 only in WR.
REQ-019 A beat SHALL complete only when bus_req && beat_ack.
- In RD: ss_xfer0=beat_ack, rd_left decrements, bcnt increments.
- In WR: ss_xfer1=beat_ack, bcnt increments.
REQ-020 ss_last0 SHALL equal ss_xfer0 && rd_left==1.
REQ-021 RD SHALL return to ARB after the completing beat when bcnt+1==BURST or rd_left==1.
- Also return to ARB on any cycle where ss_stop0=1 and beat_ack=0.
- A beat acked while ss_stop0=1 is still pushed.
REQ-022 WR SHALL go to FIN after a completing beat with ss_end1=1, otherwise to ARB after a completing beat with bcnt+1==BURST.
- ss_end1 takes precedence over BURST on the same beat.
REQ-023 FIN SHALL assert done for one cycle and return to IDLE.
- busy=1 in every state except IDLE.
REQ-024 Leaving RD/WR SHALL drop bus_req in the same cycle as the state change; no beat may be counted outside RD/WR.
REQ-025 dc0=0 SHALL be legal: no read is ever granted, and completion is driven solely by the destination side (ss_end1).
REQ-026 ctl_go outside IDLE SHALL be ignored.
REQ-027 rd_left SHALL never underflow; bcnt width is 8 bits.

Reset
REQ-028 While wb_rst_i=1, on the next edge:
- state=IDLE, rd_left=0, bcnt=0, last-grant=read (so the first tie goes to the write).
- All outputs 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no done pulse.
- The FIFOs are not cleared by this block until the next ctl_go.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- dc0=20, BURST=8, ss_start0=1, ss_stop0=0, ss_start1=0, beat_ack always 1 -> three RD grants of 8, 8 and 4 beats; ss_last0 on beat 20 only; rd_left=0.
- In ARB with both candidates after reset -> WR first; the next tie grants RD.
- RD with ss_stop0 rising at beat 3 while beat_ack=0 -> bus_req falls next cycle, 3 pushes total, back to ARB.
- WR with ss_end1=1 on beat 5 -> ss_xfer1 exactly 5 pulses, FIN, done pulses once, busy falls the following cycle.
- wb_rst_i for one cycle during RD beat 4 -> all outputs 0 next cycle; no done; a subsequent ctl_go yields a fresh m_reset0 pulse.
- ctl_go with dc0=0 and ss_start1=1, ss_end1 set on the first beat -> no RD state visited; done after 1 write beat.
